// File: rtl/hex_entry_pkg.sv
// Shared types and helpers for the hex entry controller: FSM state encoding,
// nibble width and the digit-count width function.
package hex_entry_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam int NIBBLE_W = 4;

   // Width needed to count 0..digits inclusive.
   function automatic int count_width(input int digits);
      return $clog2(digits + 1);
   endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Registered-history rising-edge detector for push-buttons. History resets to 1
// so a button already held when reset releases does not produce an edge.
module rising_edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic hist_q;
   logic hist_d;

   always_comb begin
      hist_d = level;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hist_q <= 1'b1;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign rise = level & ~hist_q;

endmodule

// File: rtl/hex_entry_controller.sv
// Collects hex keystrokes into an operand word and hands it off over valid/ready.
// Optional idle timeout of a partial entry is enabled by HEX_ENTRY_TIMEOUT_EN.
module hex_entry_controller
   import hex_entry_pkg::*;
#(
   parameter int DIGITS         = 8,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            key_valid,
   input  logic [NIBBLE_W-1:0]             key_nibble,
   input  logic                            commit,
   input  logic                            clear,
   output logic [NIBBLE_W*DIGITS-1:0]      word_data,
   output logic                            word_valid,
   input  logic                            word_ready,
   output logic [NIBBLE_W*DIGITS-1:0]      entry_value,
   output logic [count_width(DIGITS)-1:0]  digit_count,
   output logic                            overflow
);

   localparam int W     = NIBBLE_W * DIGITS;
   localparam int CNT_W = count_width(DIGITS);

   state_e             state_q, state_d;
   logic [W-1:0]       entry_q, entry_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               ovf_q, ovf_d;
   logic [W-1:0]       word_data_q, word_data_d;
   logic               word_valid_q, word_valid_d;
   logic               commit_edge, clear_edge;
   logic               key_accept;

   rising_edge_detect u_commit_edge (
      .clock (clock),
      .reset (reset),
      .level (commit),
      .rise  (commit_edge)
   );

   rising_edge_detect u_clear_edge (
      .clock (clock),
      .reset (reset),
      .level (clear),
      .rise  (clear_edge)
   );

   // Keys only count when no higher-priority button edge claims the cycle.
   assign key_accept = key_valid & ~clear_edge & ~commit_edge &
                       (state_q != HOLD) & (count_q < CNT_W'(DIGITS));

`ifdef HEX_ENTRY_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
   logic            activity;
`endif

   always_comb begin
      state_d      = state_q;
      entry_d      = entry_q;
      count_d      = count_q;
      ovf_d        = ovf_q;
      word_data_d  = word_data_q;
      word_valid_d = word_valid_q;

      if (state_q == HOLD && word_valid_q && word_ready) begin
         word_valid_d = 1'b0;
         state_d      = IDLE;
      end

      if (clear_edge) begin
         entry_d = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         if (state_q != HOLD) begin
            state_d = IDLE;
         end
      end else if (commit_edge) begin
         if (state_q == ENTRY) begin
            word_data_d  = entry_q;
            word_valid_d = 1'b1;
            entry_d      = '0;
            count_d      = '0;
            ovf_d        = 1'b0;
            state_d      = HOLD;
         end
      end else if (key_valid) begin
         if (key_accept) begin
            entry_d = {entry_q[W-NIBBLE_W-1:0], key_nibble};
            count_d = count_q + CNT_W'(1);
            state_d = ENTRY;
         end else begin
            ovf_d = 1'b1;
         end
      end

`ifdef HEX_ENTRY_TIMEOUT_EN
      activity   = clear_edge | commit_edge | key_accept;
      idle_cnt_d = '0;
      if (state_q == ENTRY && !activity) begin
         if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            entry_d = '0;
            count_d = '0;
            state_d = IDLE;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         entry_q      <= '0;
         count_q      <= '0;
         ovf_q        <= 1'b0;
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
`ifdef HEX_ENTRY_TIMEOUT_EN
         idle_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         entry_q      <= entry_d;
         count_q      <= count_d;
         ovf_q        <= ovf_d;
         word_data_q  <= word_data_d;
         word_valid_q <= word_valid_d;
`ifdef HEX_ENTRY_TIMEOUT_EN
         idle_cnt_q   <= idle_cnt_d;
`endif
      end
   end

   assign word_data   = word_data_q;
   assign word_valid  = word_valid_q;
   assign entry_value = entry_q;
   assign digit_count = count_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_hex_entry_controller.sv
// Directed self-checking bench for hex_entry_controller (DIGITS=8, TIMEOUT_CYCLES=16).
module tb_hex_entry_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        key_valid;
   logic [3:0]  key_nibble;
   logic        commit;
   logic        clear;
   logic [31:0] word_data;
   logic        word_valid;
   logic        word_ready;
   logic [31:0] entry_value;
   logic [3:0]  digit_count;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   hex_entry_controller #(
      .DIGITS         (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .key_valid   (key_valid),
      .key_nibble  (key_nibble),
      .commit      (commit),
      .clear       (clear),
      .word_data   (word_data),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .entry_value (entry_value),
      .digit_count (digit_count),
      .overflow    (overflow)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic press_key(input logic [3:0] n);
      key_valid  = 1'b1;
      key_nibble = n;
      tick();
      key_valid  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; key_valid = 1'b0; key_nibble = 4'h0;
      commit = 1'b0; clear = 1'b0; word_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
      checks++;
      if (word_valid !== 1'b0 || word_data !== 32'h0 || entry_value !== 32'h0 ||
          digit_count !== 4'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset: valid=%b data=%h entry=%h cnt=%0d ovf=%b, required 0/0/0/0/0",
                  word_valid, word_data, entry_value, digit_count, overflow);
      end
      $display("txn reset: valid=%b entry=%h cnt=%0d", word_valid, entry_value, digit_count);
   endtask

   task automatic test_basic();
      word_ready = 1'b1;
      press_key(4'h1); press_key(4'h2); press_key(4'hA); press_key(4'hF);
      checks++;
      if (entry_value !== 32'h0000_12AF || digit_count !== 4'd4) begin
         errors++;
         $display("FAIL basic_entry: entry=%h cnt=%0d, required 000012af/4", entry_value, digit_count);
      end
      commit = 1'b1; tick(); commit = 1'b0;
      checks++;
      if (word_valid !== 1'b1 || word_data !== 32'h0000_12AF) begin
         errors++;
         $display("FAIL basic_commit: valid=%b data=%h, required 1/000012af", word_valid, word_data);
      end
      checks++;
      if (entry_value !== 32'h0 || digit_count !== 4'd0) begin
         errors++;
         $display("FAIL basic_entry_cleared: entry=%h cnt=%0d, required 0/0", entry_value, digit_count);
      end
      tick();
      checks++;
      if (word_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_transfer: valid=%b, required 0", word_valid);
      end
      $display("txn basic: word 000012af delivered");
   endtask

   task automatic test_overflow();
      word_ready = 1'b0;
      for (int i = 1; i <= 8; i++) press_key(4'(i));
      checks++;
      if (entry_value !== 32'h1234_5678 || digit_count !== 4'd8 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_full: entry=%h cnt=%0d ovf=%b, required 12345678/8/0",
                  entry_value, digit_count, overflow);
      end
      press_key(4'h9);
      checks++;
      if (entry_value !== 32'h1234_5678 || digit_count !== 4'd8 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_ninth: entry=%h cnt=%0d ovf=%b, required 12345678/8/1",
                  entry_value, digit_count, overflow);
      end
      commit = 1'b1; tick(); commit = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_after_commit: ovf=%b, required 0", overflow);
      end
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (word_valid !== 1'b1 || word_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL ovf_hold_%0d: valid=%b data=%h, required 1/12345678", c, word_valid, word_data);
         end
         if (c < 5) tick();
      end
      word_ready = 1'b1;
      tick();
      checks++;
      if (word_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_transfer: valid=%b, required 0", word_valid);
      end
      $display("txn overflow: word 12345678 delivered after stall");
   endtask

   task automatic test_hold();
      word_ready = 1'b0;
      press_key(4'h3);
      commit = 1'b1; tick(); commit = 1'b0;
      press_key(4'h5);
      checks++;
      if (overflow !== 1'b1 || entry_value !== 32'h0 || word_valid !== 1'b1) begin
         errors++;
         $display("FAIL hold_key: ovf=%b entry=%h valid=%b, required 1/0/1", overflow, entry_value, word_valid);
      end
      clear = 1'b1; tick(); clear = 1'b0;
      tick();
      checks++;
      if (overflow !== 1'b0 || word_valid !== 1'b1 || word_data !== 32'h3) begin
         errors++;
         $display("FAIL hold_clear: ovf=%b valid=%b data=%h, required 0/1/3", overflow, word_valid, word_data);
      end
      word_ready = 1'b1;
      tick();
      checks++;
      if (word_valid !== 1'b0 || digit_count !== 4'd0) begin
         errors++;
         $display("FAIL hold_transfer: valid=%b cnt=%0d, required 0/0", word_valid, digit_count);
      end
      $display("txn hold: keys dropped, clear kept word 3");
   endtask

   task automatic test_same_cycle();
      word_ready = 1'b1;
      press_key(4'h4);
      clear = 1'b1; commit = 1'b1; tick(); clear = 1'b0; commit = 1'b0;
      checks++;
      if (entry_value !== 32'h0 || digit_count !== 4'd0 || word_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear_commit: entry=%h cnt=%0d valid=%b, required 0/0/0",
                  entry_value, digit_count, word_valid);
      end
      tick();
      press_key(4'h6);
      commit = 1'b1; key_valid = 1'b1; key_nibble = 4'h9;
      tick();
      commit = 1'b0; key_valid = 1'b0;
      checks++;
      if (word_valid !== 1'b1 || word_data !== 32'h6 || digit_count !== 4'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL commit_key: valid=%b data=%h cnt=%0d ovf=%b, required 1/6/0/0",
                  word_valid, word_data, digit_count, overflow);
      end
      tick();
      $display("txn same_cycle: clear beat commit, commit beat key");
   endtask

   task automatic test_reset_held();
      word_ready = 1'b0;
      press_key(4'hC);
      commit = 1'b1; tick(); commit = 1'b0;
      reset = 1'b1; commit = 1'b1; tick();
      checks++;
      if (word_valid !== 1'b0 || word_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_hold: valid=%b data=%h, required 0/0", word_valid, word_data);
      end
      reset = 1'b0; tick(); tick();
      checks++;
      if (word_valid !== 1'b0) begin
         errors++;
         $display("FAIL commit_through_reset: valid=%b, required 0", word_valid);
      end
      commit = 1'b0; tick();
      commit = 1'b1; tick(); commit = 1'b0; tick();
      checks++;
      if (word_valid !== 1'b0 || digit_count !== 4'd0) begin
         errors++;
         $display("FAIL commit_idle: valid=%b cnt=%0d, required 0/0", word_valid, digit_count);
      end
      $display("txn reset_held: no spurious word");
   endtask

   task automatic test_timeout();
      press_key(4'h7);
`ifdef HEX_ENTRY_TIMEOUT_EN
      for (int i = 0; i < 15; i++) tick();
      checks++;
      if (entry_value !== 32'h7 || digit_count !== 4'd1) begin
         errors++;
         $display("FAIL timeout_early: entry=%h cnt=%0d, required 7/1", entry_value, digit_count);
      end
      tick();
      checks++;
      if (entry_value !== 32'h0 || digit_count !== 4'd0) begin
         errors++;
         $display("FAIL timeout_fire: entry=%h cnt=%0d, required 0/0", entry_value, digit_count);
      end
`else
      for (int i = 0; i < 100; i++) tick();
      checks++;
      if (entry_value !== 32'h7 || digit_count !== 4'd1) begin
         errors++;
         $display("FAIL no_timeout: entry=%h cnt=%0d, required 7/1", entry_value, digit_count);
      end
      clear = 1'b1; tick(); clear = 1'b0; tick();
`endif
      $display("txn timeout: entry=%h", entry_value);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_hold();
      test_same_cycle();
      test_reset_held();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
